// File: rtl/store_buffer.sv
// Posted-write store buffer between M-stage store issue and the single-port data memory.
// Stores queue in a small FIFO and retire one per cycle whenever a load is not using the
// DM port; loads bypass the queue and stall only when they alias a pending store or the
// buffer is full.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW_LO = 2,
    parameter int unsigned AW_HI = 25
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_req,
    input  logic [31:0]              st_pc,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    input  logic                     st_isByte,
    input  logic                     ld_req,
    input  logic [31:0]              ld_addr,
    input  logic                     ld_isByte,
    input  logic                     sb_hold,
    output logic                     stall,
    output logic                     DM_writeMem_EN,
    output logic [31:0]              DM_ADDR,
    output logic [31:0]              DM_dataIN,
    output logic                     DM_isByte,
    output logic [31:0]              DM_PC,
    output logic [$clog2(DEPTH):0]   sb_count,
    output logic                     sb_empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic        is_byte;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            full;
    logic            ld_eff;
    logic            hit;
    logic            drain;
    logic            ld_port;
    logic            enq;
    logic            non_empty;
    logic [PW-1:0]   off;
    entry_t          head;

    // Port arbitration, alias detection and output muxing.
    always_comb begin
        full      = (count_q == CW'(DEPTH));
        non_empty = (count_q != '0);
        // A store wins over an (illegal) simultaneous load.
        ld_eff    = ld_req & ~st_req;

        hit = 1'b0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // Slot i is valid when its distance from the head is below count.
            off = PW'(i) - rd_ptr_q;
            if (({1'b0, off} < count_q) &&
                (mem_q[i].addr[AW_HI:AW_LO] == ld_addr[AW_HI:AW_LO])) begin
                hit = 1'b1;
            end
        end
        hit = hit & ld_eff;

        drain   = non_empty & ~sb_hold & (~ld_eff | hit | full);
        ld_port = ld_eff & ~drain;
        enq     = st_req & ~full;

        head = non_empty ? mem_q[rd_ptr_q] : '0;

        // An aliasing or full-buffer load also waits while draining is held off, so it can
        // never read stale data around a held store.
        stall = (st_req & full) | (ld_eff & (hit | full));

        DM_dataIN = head.data;
        DM_PC     = head.pc;
        if (ld_port) begin
            DM_ADDR        = ld_addr;
            DM_isByte      = ld_isByte;
            DM_writeMem_EN = 1'b0;
        end else begin
            DM_ADDR        = head.addr;
            DM_isByte      = head.is_byte;
            DM_writeMem_EN = drain;
        end

        sb_count = count_q;
        sb_empty = ~non_empty;
    end

    // FIFO next-state: enqueue at the tail, dequeue from the head on drain.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (enq) begin
            mem_d[wr_ptr_q] = '{pc: st_pc, addr: st_addr, data: st_data, is_byte: st_isByte};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (drain) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(enq) - CW'(drain);
    end

    // State registers; reset discards every pending store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Store and load are never issued in the same M-stage cycle.
    assert property (@(posedge clk) disable iff (reset) !(st_req && ld_req))
        else $error("store_buffer: st_req and ld_req asserted together");

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a vector table for per-cycle arbitration, hand-written
// sequences for the multi-cycle cases, and a scoreboard of expected DM writes.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_req, st_isByte, ld_req, ld_isByte, sb_hold;
    logic [31:0] st_pc, st_addr, st_data, ld_addr;
    logic        stall, DM_writeMem_EN, DM_isByte, sb_empty;
    logic [31:0] DM_ADDR, DM_dataIN, DM_PC;
    logic [2:0]  sb_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic        is_byte;
    } wr_t;

    wr_t         sb_q[$];
    logic [31:0] dmem [256];

    typedef struct {
        logic        st;
        logic [31:0] sa;
        logic [31:0] sd;
        logic        sb;
        logic        ld;
        logic [31:0] la;
        logic        lb;
        logic        hold;
        logic        e_stall;
        logic        e_we;
        logic [31:0] e_addr;
        logic        e_isb;
        int          e_cnt;
    } vec_t;

    vec_t vecs[8];

    store_buffer #(.DEPTH(4), .AW_LO(2), .AW_HI(25)) dut (
        .clk            (clk),
        .reset          (reset),
        .st_req         (st_req),
        .st_pc          (st_pc),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .st_isByte      (st_isByte),
        .ld_req         (ld_req),
        .ld_addr        (ld_addr),
        .ld_isByte      (ld_isByte),
        .sb_hold        (sb_hold),
        .stall          (stall),
        .DM_writeMem_EN (DM_writeMem_EN),
        .DM_ADDR        (DM_ADDR),
        .DM_dataIN      (DM_dataIN),
        .DM_isByte      (DM_isByte),
        .DM_PC          (DM_PC),
        .sb_count       (sb_count),
        .sb_empty       (sb_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        st_req    = 1'b0;
        st_pc     = '0;
        st_addr   = '0;
        st_data   = '0;
        st_isByte = 1'b0;
        ld_req    = 1'b0;
        ld_addr   = '0;
        ld_isByte = 1'b0;
    endtask

    // Present a new store and record the DM write it must eventually produce.
    task automatic drive_st(input logic [31:0] a, input logic [31:0] d, input logic b,
                            input logic [31:0] pc);
        wr_t w;
        drive_idle();
        st_req    = 1'b1;
        st_addr   = a;
        st_data   = d;
        st_isByte = b;
        st_pc     = pc;
        w.pc = pc; w.addr = a; w.data = d; w.is_byte = b;
        sb_q.push_back(w);
    endtask

    task automatic drive_ld(input logic [31:0] a, input logic b);
        drive_idle();
        ld_req    = 1'b1;
        ld_addr   = a;
        ld_isByte = b;
    endtask

    // Scoreboard and DM model: every write strobe must match the oldest expected store.
    always @(negedge clk) begin
        if (!reset && DM_writeMem_EN) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_unexpected: got write addr 0x%08h want no write", DM_ADDR);
            end else begin
                wr_t w;
                w = sb_q.pop_front();
                chk("wr_addr", DM_ADDR, w.addr);
                chk("wr_data", DM_dataIN, w.data);
                chk("wr_byte", 32'(DM_isByte), 32'(w.is_byte));
                chk("wr_pc", DM_PC, w.pc);
            end
            if (DM_isByte) begin
                dmem[DM_ADDR[9:2]][8*DM_ADDR[1:0] +: 8] = DM_dataIN[8*DM_ADDR[1:0] +: 8];
            end else begin
                dmem[DM_ADDR[9:2]] = DM_dataIN;
            end
        end
    end

    initial begin
        bit done;
        for (int i = 0; i < 256; i++) dmem[i] = '0;

        // st sa sd sb | ld la lb | hold | stall we addr isb cnt
        vecs[0] = '{0, 32'h0,   32'h0,        0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   0, 0};
        vecs[1] = '{1, 32'h100, 32'h11111111, 0, 0, 32'h0,   0, 1, 0, 0, 32'h0,   0, 0};
        vecs[2] = '{1, 32'h104, 32'h22222222, 1, 0, 32'h0,   0, 1, 0, 0, 32'h100, 0, 1};
        vecs[3] = '{0, 32'h0,   32'h0,        0, 1, 32'h200, 0, 0, 0, 0, 32'h200, 0, 2};
        vecs[4] = '{0, 32'h0,   32'h0,        0, 1, 32'h104, 1, 0, 1, 1, 32'h100, 0, 2};
        vecs[5] = '{0, 32'h0,   32'h0,        0, 1, 32'h104, 1, 0, 1, 1, 32'h104, 1, 1};
        vecs[6] = '{0, 32'h0,   32'h0,        0, 1, 32'h104, 1, 0, 0, 0, 32'h104, 1, 0};
        vecs[7] = '{0, 32'h0,   32'h0,        0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   0, 0};

        reset   = 1'b1;
        sb_hold = 1'b0;
        drive_idle();
        #3;
        chk("rst_empty", 32'(sb_empty), 32'd1);
        chk("rst_count", 32'(sb_count), 32'd0);
        chk("rst_we", 32'(DM_writeMem_EN), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        cyc();
        reset = 1'b0;

        // Per-cycle arbitration vectors; state carries over from one vector to the next.
        for (int i = 0; i < 8; i++) begin
            cyc();
            sb_hold = vecs[i].hold;
            if (vecs[i].st) begin
                drive_st(vecs[i].sa, vecs[i].sd, vecs[i].sb, 32'h1000 + 32'(i) * 4);
            end else if (vecs[i].ld) begin
                drive_ld(vecs[i].la, vecs[i].lb);
            end else begin
                drive_idle();
            end
            mid();
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_we", i), 32'(DM_writeMem_EN), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_addr", i), DM_ADDR, vecs[i].e_addr);
            chk($sformatf("v%0d_isb", i), 32'(DM_isByte), 32'(vecs[i].e_isb));
            chk($sformatf("v%0d_cnt", i), 32'(sb_count), 32'(vecs[i].e_cnt));
        end

        // Single store retires the following cycle.
        cyc(); drive_st(32'h10, 32'hAABBCCDD, 1'b0, 32'h2000);
        mid(); chk("t1_we_c0", 32'(DM_writeMem_EN), 32'd0);
        cyc(); drive_idle();
        mid();
        chk("t1_we_c1", 32'(DM_writeMem_EN), 32'd1);
        chk("t1_addr", DM_ADDR, 32'h10);
        chk("t1_data", DM_dataIN, 32'hAABBCCDD);
        cyc(); mid(); chk("t1_empty", 32'(sb_empty), 32'd1);

        // Fill under hold, fifth store stalls, then drains in order.
        sb_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(); drive_st(32'(i) * 4, 32'hD0 + 32'(i), 1'b0, 32'h3000 + 32'(i) * 4);
            mid(); chk($sformatf("t2_st%0d_stall", i), 32'(stall), 32'd0);
        end
        cyc(); drive_st(32'h10, 32'hD4, 1'b0, 32'h3010);
        mid();
        chk("t2_count", 32'(sb_count), 32'd4);
        chk("t2_stall5", 32'(stall), 32'd1);
        cyc(); sb_hold = 1'b0;
        mid();
        chk("t2_stall_rel", 32'(stall), 32'd1);
        chk("t2_first_addr", DM_ADDR, 32'h0);
        cyc(); mid(); chk("t2_accept", 32'(stall), 32'd0);
        cyc(); drive_idle();
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            mid();
            if (sb_empty) done = 1'b1;
            else cyc();
        end
        chk("t2_drained", 32'(done), 32'd1);

        // Aliasing load waits for the held store, then reads the new data.
        cyc(); sb_hold = 1'b1; drive_st(32'h20, 32'hCAFEF00D, 1'b0, 32'h4000);
        mid();
        cyc(); drive_ld(32'h20, 1'b0);
        mid();
        chk("t3_stall_hold", 32'(stall), 32'd1);
        chk("t3_we_hold", 32'(DM_writeMem_EN), 32'd0);
        cyc(); sb_hold = 1'b0;
        mid();
        chk("t3_stall_drain", 32'(stall), 32'd1);
        chk("t3_we_drain", 32'(DM_writeMem_EN), 32'd1);
        cyc(); mid();
        chk("t3_stall_done", 32'(stall), 32'd0);
        chk("t3_ld_addr", DM_ADDR, 32'h20);
        chk("t3_ld_data", dmem[8], 32'hCAFEF00D);
        cyc(); drive_idle();

        // Non-aliasing byte load bypasses a held store.
        sb_hold = 1'b1; drive_st(32'h40, 32'h12345678, 1'b0, 32'h5000);
        mid();
        cyc(); drive_ld(32'h31, 1'b1);
        mid();
        chk("t4_stall", 32'(stall), 32'd0);
        chk("t4_addr", DM_ADDR, 32'h31);
        chk("t4_isb", 32'(DM_isByte), 32'd1);
        chk("t4_we", 32'(DM_writeMem_EN), 32'd0);
        cyc(); drive_idle(); sb_hold = 1'b0;
        mid(); chk("t4_drain", 32'(DM_writeMem_EN), 32'd1);

        // Byte store updates only its lane.
        cyc(); drive_st(32'h42, 32'h00AB0000, 1'b1, 32'h6000);
        mid();
        cyc(); drive_idle();
        mid();
        chk("t5_we", 32'(DM_writeMem_EN), 32'd1);
        chk("t5_addr", DM_ADDR, 32'h42);
        chk("t5_isb", 32'(DM_isByte), 32'd1);
        cyc(); mid();
        chk("t5_word", dmem[16], 32'h12AB5678);

        // Asynchronous reset mid-cycle discards pending stores.
        sb_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); drive_st(32'h80 + 32'(i) * 4, 32'hE0 + 32'(i), 1'b0, 32'h7000 + 32'(i) * 4);
        end
        cyc(); drive_idle();
        mid(); chk("t6_pending", 32'(sb_count), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_count", 32'(sb_count), 32'd0);
        chk("t6_empty", 32'(sb_empty), 32'd1);
        chk("t6_we", 32'(DM_writeMem_EN), 32'd0);
        sb_q.delete();
        cyc(); reset = 1'b0; sb_hold = 1'b0;
        repeat (5) begin
            cyc(); mid();
        end
        chk("t6_still_empty", 32'(sb_empty), 32'd1);

        chk("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
